// File: rtl/rsa_pkg.sv
// Shared definitions for the modular-exponentiation sequencer and the
// operand muxes it steers in the datapath.
package rsa_pkg;

  // Sequencer steps; every state other than IDLE and FIN is one multiplication.
  typedef enum logic [2:0] {
    IDLE,
    PRE,
    INIT,
    SQ,
    MUL,
    POST,
    FIN
  } state_t;

  // Operand mux select codes: a, b, constant one, constant zero.
  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_ONE  = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

endpackage

// File: rtl/rsa_expo_ctrl.sv
// Left-to-right square-and-multiply sequencer for C = M^E mod N.
// Each multiply step is a one-cycle ISSUE (mmm_start) followed by a WAIT that
// lasts until mmm_done. The step's result is written to exactly one register.
module rsa_expo_ctrl
  import rsa_pkg::*;
#(
  parameter int EXP_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic                 mmm_done,
  output logic                 mmm_start,
  output logic [1:0]           sel_x,
  output logic [1:0]           sel_y,
  output logic                 mbar_we,
  output logic                 acc_we,
  output logic                 res_we,
  output logic                 busy,
  output logic                 done
);

  localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_WIDTH - 1);

  state_t               state_reg, state_next;
  logic                 wait_reg, wait_next;   // 0 = ISSUE phase, 1 = WAIT phase
  logic [IDX_W-1:0]     idx_reg, idx_next;     // current exponent bit
  logic [EXP_WIDTH-1:0] exp_reg, exp_next;     // exponent captured at start
  logic                 mul_state;
  logic                 step_done;
  logic                 bit_set;

  // State, phase, bit index and latched exponent registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      wait_reg  <= 1'b0;
      idx_reg   <= '0;
      exp_reg   <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      idx_reg   <= idx_next;
      exp_reg   <= exp_next;
    end
  end

  // Next-state logic, operand selects, multiplier request and write-enables.
  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    idx_next   = idx_reg;
    exp_next   = exp_reg;
    mmm_start  = 1'b0;
    sel_x      = SEL_ZERO;
    sel_y      = SEL_ZERO;
    mbar_we    = 1'b0;
    acc_we     = 1'b0;
    res_we     = 1'b0;
    done       = 1'b0;
    busy       = (state_reg != IDLE);
    bit_set    = exp_reg[idx_reg];

    mul_state = (state_reg inside {PRE, INIT, SQ, MUL, POST});
    // A completion only counts once the request has been issued.
    step_done = mul_state && wait_reg && mmm_done;

    if (mul_state) begin
      mmm_start = !wait_reg;
      if (!wait_reg) begin
        wait_next = 1'b1;
      end else if (mmm_done) begin
        wait_next = 1'b0;
      end
    end

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = PRE;
          exp_next   = exponent;
          wait_next  = 1'b0;
        end
      end
      PRE: begin
        // M * R^2 * R^-1 = M*R: message into the Montgomery domain.
        sel_x   = SEL_B;
        sel_y   = SEL_B;
        mbar_we = step_done;
        if (step_done) state_next = INIT;
      end
      INIT: begin
        // R^2 * 1 * R^-1 = R: Montgomery form of 1 seeds the accumulator.
        sel_x  = SEL_B;
        sel_y  = SEL_ONE;
        acc_we = step_done;
        if (step_done) begin
          state_next = SQ;
          idx_next   = IDX_TOP;
        end
      end
      SQ: begin
        sel_x  = SEL_A;
        sel_y  = SEL_A;
        acc_we = step_done;
        if (step_done) begin
          if (bit_set) begin
            state_next = MUL;
          end else if (idx_reg == '0) begin
            state_next = POST;
          end else begin
            idx_next = idx_reg - 1'b1;
          end
        end
      end
      MUL: begin
        sel_x  = SEL_A;
        sel_y  = SEL_B;
        acc_we = step_done;
        if (step_done) begin
          if (idx_reg == '0) begin
            state_next = POST;
          end else begin
            state_next = SQ;
            idx_next   = idx_reg - 1'b1;
          end
        end
      end
      POST: begin
        // Multiply by plain 1 to leave the Montgomery domain.
        sel_x  = SEL_A;
        sel_y  = SEL_ONE;
        res_we = step_done;
        if (step_done) state_next = FIN;
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
